gate_thresh_sched: RTL and testbench
====================================

Name: gate_thresh_sched

Overview:
- Controls the 1024-sample running-mean estimator that follows the QAM16 demodulator. The estimator's output is the mean of |x|, and that value is the ±1/±3 decision threshold for one I or Q rail.
- Waits until the estimator window has filled, then loads its mean into a threshold register at a fixed period. Freeze requests can hold the threshold.
- Slices each symbol-centre sample into 2 decision bits, marked valid only once the threshold is valid.
- Runs on the 8 MHz receiver clock. One instance per rail.

Parameters:
- WIN_LEN, 1024, estimator window length in clocks; sets the fill wait.
- UPD_PERIOD, 256, clocks between threshold updates while tracking.
- CNT_W, 11, counter width; must satisfy 2^CNT_W > max(WIN_LEN, UPD_PERIOD).

Ports:
- clk  in  1  system clock, 8 MHz
- rst  in  1  asynchronous reset, active-high
- enable  in  1  level; 1 = run, 0 = return to IDLE
- freeze  in  1  level; 1 = hold threshold (no updates)
- mean  in  26  signed estimator mean (|x| average)
- din  in  26  signed baseband sample, same timing as the estimator input
- sym_stb  in  1  one-cycle symbol-centre strobe from bit sync
- thr  out  26  signed current threshold
- thr_valid  out  1  threshold has been loaded at least once since FILL
- dout  out  2  decision {sign, mag}
- dout_valid  out  1  one-cycle strobe; dout is new this cycle
- state_o  out  2  FSM state, for debug

Behaviour:
- Reset values (asynchronous, rst high): state=IDLE, cnt=0, thr=0, thr_valid=0, dout=2'b00, dout_valid=0.
- IDLE (00): thr_valid=0, cnt=0. When enable=1, go to FILL next cycle.
- FILL (01): cnt increments every clock. On the cycle where cnt==WIN_LEN-1:
  - thr<=mean; thr_valid<=1; cnt<=0; go to TRACK.
  - freeze is ignored in FILL; the first load always happens.
- TRACK (10): cnt increments every clock and wraps at UPD_PERIOD-1.
  - On wrap: if freeze=0, thr<=mean; if freeze=1, thr holds. The wrap still resets cnt either way.
- HOLD (11): entered from TRACK when freeze rises.
  - cnt is held; thr is held.
  - When freeze falls: return to TRACK with cnt=0, and the next update comes UPD_PERIOD clocks later.
- enable=0 in any state: go to IDLE next cycle; thr_valid<=0; thr keeps its value.
- enable=0 wins over every other event in the same cycle.
- Decision path (any state):
  - On sym_stb=1 with thr_valid=1 in the same cycle, register dout and pulse dout_valid=1 for one cycle. Latency is 1 clk from sym_stb.
  - sign = din[25]. mag = 1 when |din| >= thr.
  - |din| is computed at 26 bits; din = -2^25 saturates to 2^25-1.
  - thr is compared as non-negative; if thr<0, mag is taken against 0.
  - sym_stb with thr_valid=0: no dout_valid; dout holds.
- Simultaneous threshold update and sym_stb: the decision uses the thr value from before the update (registered compare).
- Reset mid-operation: immediate return to reset values; no partial outputs.

Optional Feature:
- Macro: GATE_THR_SMOOTH_EN.
- Defined: every update after the first (TRACK wrap) becomes thr <= thr + ((mean - thr) >>> 2).
  - Uses a 27-bit signed intermediate, arithmetic shift, truncated to 26 bits.
  - The first load in FILL is still a direct copy of mean.
- Not defined: every update is a direct copy, thr<=mean.

Decomposition:
- Shared package gate_pkg holds:
  - state encoding constants ST_IDLE=2'b00, ST_FILL=2'b01, ST_TRACK=2'b10, ST_HOLD=2'b11
  - DATA_W=26
  - default WIN_LEN and UPD_PERIOD values
- One natural sub-module: gate_slicer, containing the abs/saturate/compare and dout register (inputs din, thr, sym_stb, thr_valid).
- The FSM and counter stay in gate_thresh_sched.

Test Plan:
- Reset and fill: hold rst 5 clks, set enable=1, mean=1000 constant.
  - state_o goes 01 one cycle later.
  - thr=1000 and thr_valid=1 exactly 1024 clks after FILL entry.
- Periodic update: in TRACK, step mean 1000→2000.
  - thr changes to 2000 at the next cnt wrap (≤256 clks), not before.
  - With GATE_THR_SMOOTH_EN defined, thr becomes 1250, then 1437.
- Slicing: thr=1000; pulse sym_stb with din=+1500, -300, -1000, then -2^25.
  - dout = 01, 10, 11, 11, each followed next cycle by a one-clk dout_valid.
- Freeze: assert freeze for 600 clks while mean changes.
  - thr is constant and state_o=11.
  - After release, the first update happens 256 clks later.
- Gating: sym_stb during FILL → no dout_valid. Drop enable mid-TRACK → IDLE next clk, thr_valid=0, thr retained.
- Async reset mid-TRACK: rst pulse not aligned to clk → all outputs at reset values immediately, FILL restarts from 0 after enable.

Source files
------------

// File: rtl/gate_pkg.sv
// gate_pkg: shared definitions for the gated threshold scheduler.
//   state_t     : FSM encoding (IDLE=00, FILL=01, TRACK=10, HOLD=11)
//   DATA_W      : sample / threshold width
//   *_DEF       : default window length and update period
package gate_pkg;

    localparam int DATA_W         = 26;
    localparam int WIN_LEN_DEF    = 1024;
    localparam int UPD_PERIOD_DEF = 256;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_FILL  = 2'b01,
        ST_TRACK = 2'b10,
        ST_HOLD  = 2'b11
    } state_t;

endpackage

// File: rtl/gate_slicer.sv
// gate_slicer: 2-bit QAM16 rail decision against the current threshold.
//   clk, rst      : clock, asynchronous active-high reset
//   din           : signed baseband sample
//   thr           : signed threshold (negative treated as 0)
//   sym_stb       : symbol-centre strobe
//   thr_valid     : decisions only issued while threshold is valid
//   dout          : registered {sign, mag}
//   dout_valid    : one-cycle strobe, 1 clk after an accepted sym_stb
module gate_slicer
    import gate_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] din,
    input  logic [DATA_W-1:0] thr,
    input  logic              sym_stb,
    input  logic              thr_valid,
    output logic [1:0]        dout,
    output logic              dout_valid
);

    logic [DATA_W-1:0] din_neg;
    logic [DATA_W-1:0] din_abs;
    logic [DATA_W-1:0] thr_cmp;
    logic              mag;

    always_comb begin
        din_neg = -din;
        din_abs = din;
        if (din[DATA_W-1]) begin
            // Most-negative input negates to itself; clamp to the largest positive.
            if (din_neg[DATA_W-1])
                din_abs = {1'b0, {(DATA_W-1){1'b1}}};
            else
                din_abs = din_neg;
        end
        thr_cmp = thr[DATA_W-1] ? '0 : thr;
        mag     = (din_abs >= thr_cmp);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout       <= 2'b00;
            dout_valid <= 1'b0;
        end else begin
            dout_valid <= 1'b0;
            if (sym_stb && thr_valid) begin
                dout       <= {din[DATA_W-1], mag};
                dout_valid <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/gate_thresh_sched.sv
// gate_thresh_sched: waits for the running-mean window to fill, then loads the
// estimator mean into the decision threshold every UPD_PERIOD clocks; freeze
// holds the threshold. Slices symbol-centre samples through gate_slicer.
//   clk, rst   : clock, asynchronous active-high reset
//   enable     : 1 = run, 0 = return to IDLE
//   freeze     : 1 = hold threshold
//   mean, din  : signed estimator mean and baseband sample
//   sym_stb    : symbol-centre strobe
//   thr        : current threshold, thr_valid : loaded since FILL
//   dout       : {sign, mag}, dout_valid : one-cycle strobe
//   state_o    : FSM state (debug)
// Optional: `define GATE_THR_SMOOTH_EN makes TRACK updates a 1/4-step IIR
// toward mean instead of a direct copy.
module gate_thresh_sched
    import gate_pkg::*;
#(
    parameter int WIN_LEN    = WIN_LEN_DEF,
    parameter int UPD_PERIOD = UPD_PERIOD_DEF,
    parameter int CNT_W      = 11
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              freeze,
    input  logic [DATA_W-1:0] mean,
    input  logic [DATA_W-1:0] din,
    input  logic              sym_stb,
    output logic [DATA_W-1:0] thr,
    output logic              thr_valid,
    output logic [1:0]        dout,
    output logic              dout_valid,
    output logic [1:0]        state_o
);

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [DATA_W-1:0]  thr_upd;

`ifdef GATE_THR_SMOOTH_EN
    logic signed [DATA_W:0] diff;
    logic signed [DATA_W:0] step;
    logic        [DATA_W:0] sum;

    always_comb begin
        diff    = $signed({mean[DATA_W-1], mean}) - $signed({thr[DATA_W-1], thr});
        step    = diff >>> 2;
        sum     = {thr[DATA_W-1], thr} + step;
        thr_upd = sum[DATA_W-1:0];
    end
`else
    always_comb begin
        thr_upd = mean;
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            thr       <= '0;
            thr_valid <= 1'b0;
        end else if (!enable) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            thr_valid <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    cnt       <= '0;
                    thr_valid <= 1'b0;
                    state     <= ST_FILL;
                end
                ST_FILL: begin
                    if (cnt == CNT_W'(WIN_LEN - 1)) begin
                        thr       <= mean;
                        thr_valid <= 1'b1;
                        cnt       <= '0;
                        state     <= ST_TRACK;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_TRACK: begin
                    if (cnt == CNT_W'(UPD_PERIOD - 1)) begin
                        cnt <= '0;
                        if (!freeze)
                            thr <= thr_upd;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                    if (freeze)
                        state <= ST_HOLD;
                end
                ST_HOLD: begin
                    if (!freeze) begin
                        cnt   <= '0;
                        state <= ST_TRACK;
                    end
                end
            endcase
        end
    end

    assign state_o = state;

    gate_slicer u_slicer (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .thr        (thr),
        .sym_stb    (sym_stb),
        .thr_valid  (thr_valid),
        .dout       (dout),
        .dout_valid (dout_valid)
    );

endmodule

// File: tb/tb_gate_thresh_sched.sv
module tb_gate_thresh_sched;

    logic        clk;
    logic        rst;
    logic        enable;
    logic        freeze;
    logic [25:0] mean;
    logic [25:0] din;
    logic        sym_stb;
    logic [25:0] thr;
    logic        thr_valid;
    logic [1:0]  dout;
    logic        dout_valid;
    logic [1:0]  state_o;

    int unsigned n_checks;
    int unsigned n_fail;

`ifdef GATE_THR_SMOOTH_EN
    localparam logic [25:0] THR_UPD1 = 26'd1250;
    localparam logic [25:0] THR_UPD2 = 26'd1437;
    localparam logic [25:0] THR_UPD3 = 26'd1827;
`else
    localparam logic [25:0] THR_UPD1 = 26'd2000;
    localparam logic [25:0] THR_UPD2 = 26'd2000;
    localparam logic [25:0] THR_UPD3 = 26'd3000;
`endif

    gate_thresh_sched dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .freeze     (freeze),
        .mean       (mean),
        .din        (din),
        .sym_stb    (sym_stb),
        .thr        (thr),
        .thr_valid  (thr_valid),
        .dout       (dout),
        .dout_valid (dout_valid),
        .state_o    (state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // advance n rising edges, then settle 1 time unit past the edge
    task automatic tick(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_state"}, 32'(state_o), 32'd0);
        check({tag, "_thr"}, 32'(thr), 32'd0);
        check({tag, "_thr_valid"}, 32'(thr_valid), 32'd0);
        check({tag, "_dout"}, 32'(dout), 32'd0);
        check({tag, "_dout_valid"}, 32'(dout_valid), 32'd0);
    endtask

    // one slicing vector: strobe, decision next cycle, strobe gone the cycle after
    task automatic slice(input string tag, input logic [25:0] d, input logic [1:0] exp);
        din     = d;
        sym_stb = 1'b1;
        tick(1);
        sym_stb = 1'b0;
        check({tag, "_dout"}, 32'(dout), 32'(exp));
        check({tag, "_valid"}, 32'(dout_valid), 32'd1);
        tick(1);
        check({tag, "_valid_drop"}, 32'(dout_valid), 32'd0);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        enable   = 1'b0;
        freeze   = 1'b0;
        mean     = 26'd1000;
        din      = '0;
        sym_stb  = 1'b0;

        tick(5);
        check_reset_vals("rst_hold");
        rst = 1'b0;
        tick(1);
        check("idle_state", 32'(state_o), 32'd0);

        // fill: FILL entry at edge E; first load visible at E+1024
        enable = 1'b1;
        tick(1);
        check("fill_state", 32'(state_o), 32'd1);
        din     = 26'd5;
        sym_stb = 1'b1;
        tick(1);
        sym_stb = 1'b0;
        check("fill_stb_gated", 32'(dout_valid), 32'd0);
        tick(1022);
        check("fill_pre_valid", 32'(thr_valid), 32'd0);
        check("fill_pre_thr", 32'(thr), 32'd0);
        tick(1);
        check("fill_thr", 32'(thr), 32'd1000);
        check("fill_valid", 32'(thr_valid), 32'd1);
        check("track_state", 32'(state_o), 32'd2);

        // slicing with thr=1000 (TRACK entry edge P, now at P+1)
        tick(1);
        slice("sl_p1500", 26'd1500, 2'b01);
        slice("sl_m300", -26'sd300, 2'b10);
        slice("sl_m1000", -26'sd1000, 2'b11);
        slice("sl_min", 26'h2000000, 2'b11);

        // periodic update: now at P+9, wrap visible at P+256
        mean = 26'd2000;
        tick(246);
        check("upd_before", 32'(thr), 32'd1000);
        // strobe coincides with the wrap: decision must use the old threshold
        din     = 26'd1100;
        sym_stb = 1'b1;
        tick(1);
        sym_stb = 1'b0;
        check("upd_thr1", 32'(thr), 32'(THR_UPD1));
        check("upd_same_cycle_dout", 32'(dout), 32'd1);
        tick(255);
        check("upd2_before", 32'(thr), 32'(THR_UPD1));
        tick(1);
        check("upd_thr2", 32'(thr), 32'(THR_UPD2));

        // freeze for 600 clks while mean changes
        freeze = 1'b1;
        mean   = 26'd3000;
        tick(1);
        check("hold_state", 32'(state_o), 32'd3);
        tick(598);
        check("hold_state_end", 32'(state_o), 32'd3);
        check("hold_thr", 32'(thr), 32'(THR_UPD2));
        freeze = 1'b0;
        tick(1);
        check("unfreeze_state", 32'(state_o), 32'd2);
        tick(255);
        check("unfreeze_before", 32'(thr), 32'(THR_UPD2));
        tick(1);
        check("unfreeze_upd", 32'(thr), 32'(THR_UPD3));

        // drop enable mid-TRACK
        tick(3);
        enable = 1'b0;
        tick(1);
        check("disable_state", 32'(state_o), 32'd0);
        check("disable_valid", 32'(thr_valid), 32'd0);
        check("disable_thr", 32'(thr), 32'(THR_UPD3));

        // re-enable: first load in FILL is a direct copy in both builds
        enable = 1'b1;
        tick(1);
        check("refill_state", 32'(state_o), 32'd1);
        tick(1024);
        check("refill_thr", 32'(thr), 32'd3000);
        check("refill_valid", 32'(thr_valid), 32'd1);

        // asynchronous reset pulse between clock edges
        tick(10);
        #3;
        rst = 1'b1;
        #1;
        check_reset_vals("async_rst");
        #2;
        rst = 1'b0;
        tick(1);
        check("rst_refill_state", 32'(state_o), 32'd1);
        tick(1023);
        check("rst_refill_pre", 32'(thr_valid), 32'd0);
        tick(1);
        check("rst_refill_valid", 32'(thr_valid), 32'd1);
        check("rst_refill_thr", 32'(thr), 32'd3000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
